program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream writer that fills the instruction memory before the processor runs, then releases the processor core with a one-cycle start pulse.
- The processor reads instruction memory; this block is the write side of that memory.
- Sits between a host byte source (UART receiver or test harness) and the instruction-memory write port.
- Frame format: sync 0xA5, length (16-bit, little-endian, in words), 4·N data bytes (each word little-endian), XOR checksum byte.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted length; must be ≤ 2^ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- byte_valid  in  1  host has a byte on byte_data.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- rearm  in  1  return from DONE/ERR to IDLE; ignored in all other states.
- im_we  out  1  instruction-memory write enable, one cycle per word.
- im_addr  out  ADDR_W  word index being written.
- im_wdata  out  32  assembled instruction word.
- start  out  1  one-cycle pulse to the processor core (PC start input) after a good frame.
- done  out  1  level; high in DONE.
- error  out  1  level; high in ERR.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0 except byte_ready=1.
  - Word counter, byte index, checksum accumulator, length register and word buffer cleared.
  - Reset mid-frame discards the partial frame; words already written are not undone.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: byte_ready=1. A transfer equal to SYNC_BYTE → LEN_LO and clears the checksum. Any other byte is dropped and the state stays IDLE.
- LEN_LO / LEN_HI:
  - Capture length[7:0] then length[15:8]; each byte is XORed into the checksum.
  - On the LEN_HI transfer:
    - length > MAX_WORDS → ERR;
    - length == 0 → CSUM;
    - otherwise → DATA with word counter 0 and byte index 0.
- DATA: byte_ready=1. Each transfer writes byte_data into word-buffer lane [8·idx+7:8·idx] (byte 0 is the LSB) and XORs it into the checksum. The transfer at idx=3 → WRITE.
- WRITE (exactly one cycle): byte_ready=0, im_we=1, im_addr=word counter, im_wdata=buffer. Then the word counter increments; → CSUM if counter+1 == length, else → DATA with idx=0.
- Write latency: im_we is asserted the cycle after the 4th byte of a word is accepted.
- CSUM: byte_ready=1. On transfer:
  - byte_data == accumulator → DONE, and start=1 on the cycle of entry only;
  - otherwise → ERR.
- DONE: done=1, byte_ready=0, start=0 after the first cycle.
- ERR: error=1, byte_ready=0.
- rearm=1 in DONE or ERR → IDLE next cycle with done, error and the accumulator cleared.
- Word-counter width: ADDR_W+1 bits so that MAX_WORDS=256 does not wrap. im_addr is the counter's low ADDR_W bits.
- byte_valid without byte_ready has no effect. Bytes are never buffered internally.
- The checksum covers the length and data bytes only; the sync byte is excluded.

Decomposition:
- Package loader_pkg: state enum type, SYNC_BYTE default, frame-field constants.
- Sub-module byte_packer: byte index counter plus 32-bit lane assembly, with a word_full output. Everything else stays in program_loader.

Test Plan:
- Good 2-word frame: A5 02 00 | 78 56 34 12 | EF BE AD DE | csum=02^00^78^56^34^12^EF^BE^AD^DE.
  - Expect im_we at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF.
  - Expect one start pulse, then done=1, error=0.
- Bad checksum: same frame with csum XOR 0x01.
  - Both words are still written; error=1, start never pulses.
  - rearm → IDLE, error=0.
- Length too large: A5 01 01 (257).
  - ERR right after the LEN_HI byte, no im_we.
- Zero length and junk before sync:
  - 00 FF A5 00 00 00 → junk ignored, no writes, start pulse, done=1.
- Back-pressure and stall:
  - byte_valid held high through WRITE: the next byte is not consumed until byte_ready=1.
  - Random byte_valid gaps: identical writes to the good-frame case.
- Async reset mid-DATA: drop rst after 2 data bytes.
  - Outputs go to reset values immediately.
  - A fresh good frame afterwards loads correctly from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and frame constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         BYTE_W         = 8;
  localparam int         LEN_W          = 16;
  localparam int         WORD_W         = BYTES_PER_WORD * BYTE_W;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a word: byte index counter plus per-lane registers.
module byte_packer
  import loader_pkg::*;
#(
  parameter int NUM_LANES = BYTES_PER_WORD,
  parameter int VEC_W     = BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       load,
  input  logic [VEC_W-1:0]           byte_data,
  output logic [NUM_LANES*VEC_W-1:0] word,
  output logic                       word_full
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LANES - 1);

  logic [IDX_W-1:0]                idx;
  logic [NUM_LANES-1:0][VEC_W-1:0] lanes;

  // Byte index walks 0..NUM_LANES-1 and wraps on the word's last byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           idx <= '0;
    else if (clr)       idx <= '0;
    else if (load)      idx <= (idx == LAST) ? '0 : idx + 1'b1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [VEC_W-1:0] q;
    // Each lane captures the byte when the index points at it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               q <= '0;
      else if (load && idx == IDX_W'(g))      q <= byte_data;
    end
    assign lanes[g] = q;
  end

  assign word      = lanes;
  assign word_full = load && (idx == LAST);

endmodule

// File: rtl/program_loader.sv
// Frame parser that writes a host byte stream into instruction memory, then starts the core.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              rearm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              start,
  output logic              done,
  output logic              error
);

  state_t           state, nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_full;
  logic [ADDR_W:0]  wcnt;      // one extra bit so a full MAX_WORDS load does not wrap
  logic [7:0]       csum;
  logic             start_q;
  logic             xfer;
  logic             last_word;
  logic             csum_hit;
  logic [WORD_W-1:0] word;
  logic             word_full;

  assign xfer      = byte_valid && byte_ready;
  assign len_full  = {byte_data, len[7:0]};
  assign last_word = (LEN_W'(wcnt) + 1'b1) == len;
  assign csum_hit  = byte_valid && (byte_data == csum);

  byte_packer #(.NUM_LANES(BYTES_PER_WORD), .VEC_W(BYTE_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == S_LEN_HI),
    .load      (byte_valid && state == S_DATA),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    nxt        = state;
    byte_ready = 1'b0;
    case (state)
      S_IDLE: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_data == SYNC_BYTE) nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_full > LEN_W'(MAX_WORDS)) nxt = S_ERR;
          else if (len_full == '0)          nxt = S_CSUM;
          else                              nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (word_full) nxt = S_WRITE;
      end
      S_WRITE: nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) nxt = csum_hit ? S_DONE : S_ERR;
      end
      S_DONE:  if (rearm) nxt = S_IDLE;
      S_ERR:   if (rearm) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Length capture, word counter, running XOR checksum and the start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len     <= '0;
      wcnt    <= '0;
      csum    <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= (state == S_CSUM) && csum_hit;
      case (state)
        S_IDLE:   if (xfer && byte_data == SYNC_BYTE) csum <= '0;
        S_LEN_LO: if (xfer) begin
          len[7:0] <= byte_data;
          csum     <= csum ^ byte_data;
        end
        S_LEN_HI: if (xfer) begin
          len[15:8] <= byte_data;
          csum      <= csum ^ byte_data;
          wcnt      <= '0;
        end
        S_DATA:   if (xfer) csum <= csum ^ byte_data;
        S_WRITE:  wcnt <= wcnt + 1'b1;
        S_DONE:   if (rearm) csum <= '0;
        S_ERR:    if (rearm) csum <= '0;
        default:  ;
      endcase
    end
  end

  assign im_we    = (state == S_WRITE);
  assign im_addr  = wcnt[ADDR_W-1:0];
  assign im_wdata = word;
  assign start    = start_q;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized frames vs a frame model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        rearm = 1'b0;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        start, done, error;

  program_loader #(.ADDR_W(8), .MAX_WORDS(256), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .rearm(rearm), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .start(start), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit [7:0]    tx[$];
  logic [39:0] got_w[$];
  logic [39:0] exp_w[$];
  int          start_cnt = 0;
  int          ready_in_write = 0;
  bit          exp_done, exp_err;
  int          exp_start;

  // Observe writes and start pulses away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (im_we) got_w.push_back({im_addr, im_wdata});
      if (start) start_cnt++;
      if (im_we && byte_ready) ready_in_write++;
    end
  end

  // Frame-level reference: find sync, read length, gather words, verify XOR.
  function automatic void model();
    int i = 0;
    int len;
    bit [7:0] x;
    logic [31:0] wd;
    exp_w.delete(); exp_done = 0; exp_err = 0; exp_start = 0;
    while (i < tx.size() && tx[i] != 8'hA5) i++;
    if (i + 2 >= tx.size()) return;
    len = int'(tx[i+1]) + 256 * int'(tx[i+2]);
    x = tx[i+1] ^ tx[i+2];
    i += 3;
    if (len > 256) begin exp_err = 1; return; end
    for (int w = 0; w < len; w++) begin
      wd = 32'h0;
      for (int b = 0; b < 4; b++) begin
        wd = wd | (32'(tx[i]) << (8 * b));
        x ^= tx[i];
        i++;
      end
      exp_w.push_back({8'(w), wd});
    end
    if (tx[i] == x) begin exp_done = 1; exp_start = 1; end
    else exp_err = 1;
  endfunction

  task automatic make_frame(input int len, input bit corrupt);
    bit [7:0] x, b;
    tx.delete();
    tx.push_back(8'hA5);
    tx.push_back(8'(len)); tx.push_back(8'(len >> 8));
    x = 8'(len) ^ 8'(len >> 8);
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom);
      tx.push_back(b);
      x ^= b;
    end
    tx.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic load_good();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
  endtask

  task automatic send(input int gap_max);
    int w;
    for (int i = 0; i < tx.size(); i++) begin
      repeat (gap_max > 0 ? $urandom_range(0, gap_max) : 0) begin
        @(negedge clk); byte_valid = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = tx[i];
      w = 0;
      while (!byte_ready && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: byte %0d never accepted, wanted byte_ready=1", i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_rearm();
    @(negedge clk); rearm = 1'b1;
    @(negedge clk); rearm = 1'b0;
    got_w.delete();
    start_cnt = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({byte_ready, im_we, start, done, error, im_addr, im_wdata} !== {1'b1, 4'b0, 8'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b st=%b dn=%b er=%b a=%h d=%h want rdy=1 rest 0",
               byte_ready, im_we, start, done, error, im_addr, im_wdata);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    load_good();
    send(0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_w.size() != 2) begin n_bad++; $display("FAIL good_nwrites: got %0d want 2", got_w.size()); end
    else begin
      n_cmp++;
      if (got_w[0] !== {8'h00, 32'h12345678}) begin n_bad++; $display("FAIL good_w0: got %h want 0012345678", got_w[0]); end
      n_cmp++;
      if (got_w[1] !== {8'h01, 32'hDEADBEEF}) begin n_bad++; $display("FAIL good_w1: got %h want 01deadbeef", got_w[1]); end
    end
    n_cmp++;
    if (start_cnt != 1) begin n_bad++; $display("FAIL good_start: got %0d pulses want 1", start_cnt); end
    n_cmp++;
    if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL good_status: got done=%b err=%b want 1 0", done, error); end
    n_cmp++;
    if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL done_ready: got %b want 0", byte_ready); end
    do_rearm();
    n_cmp++;
    if ({done, byte_ready} !== 2'b01) begin n_bad++; $display("FAIL good_rearm: got done=%b rdy=%b want 0 1", done, byte_ready); end
  endtask

  task automatic test_bad_csum();
    load_good();
    tx[11] = 8'h29;
    send(0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_w.size() != 2 || got_w[0] !== {8'h00, 32'h12345678} || got_w[1] !== {8'h01, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL bad_writes: got %0d writes want 2 correct words", got_w.size());
    end
    n_cmp++;
    if ({error, done, start_cnt != 0} !== 3'b100) begin
      n_bad++; $display("FAIL bad_status: got err=%b done=%b starts=%0d want 1 0 0", error, done, start_cnt);
    end
    do_rearm();
    n_cmp++;
    if ({error, byte_ready} !== 2'b01) begin n_bad++; $display("FAIL bad_rearm: got err=%b rdy=%b want 0 1", error, byte_ready); end
  endtask

  task automatic test_len_too_large();
    tx = '{8'hA5, 8'h01, 8'h01};
    send(0);
    n_cmp++;
    if (error !== 1'b1) begin n_bad++; $display("FAIL len_big_err: got %b want 1", error); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_w.size() != 0) begin n_bad++; $display("FAIL len_big_writes: got %0d want 0", got_w.size()); end
    do_rearm();
  endtask

  task automatic test_zero_len_junk();
    tx = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send(0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({got_w.size() == 0, start_cnt == 1, done, error} !== 4'b1110) begin
      n_bad++; $display("FAIL zero_len: got writes=%0d starts=%0d done=%b err=%b want 0 1 1 0",
                        got_w.size(), start_cnt, done, error);
    end
    do_rearm();
  endtask

  task automatic test_back_to_back();
    int lens[5];
    bit bad[5];
    int gaps[5];
    lens = '{2, 256, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 4)};
    bad  = '{0, 0, 0, 0, 1};
    gaps = '{3, 0, 0, 4, 2};
    for (int f = 0; f < 5; f++) begin
      make_frame(lens[f], bad[f]);
      model();
      send(gaps[f]);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (got_w.size() != exp_w.size()) begin
        n_bad++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", f, got_w.size(), exp_w.size());
      end else begin
        for (int k = 0; k < exp_w.size(); k++) begin
          n_cmp++;
          if (got_w[k] !== exp_w[k]) begin n_bad++; $display("FAIL rnd%0d_w%0d: got %h want %h", f, k, got_w[k], exp_w[k]); end
        end
      end
      n_cmp++;
      if ({start_cnt, done, error} !== {exp_start, exp_done, exp_err}) begin
        n_bad++; $display("FAIL rnd%0d_status: got st=%0d dn=%b er=%b want %0d %b %b",
                          f, start_cnt, done, error, exp_start, exp_done, exp_err);
      end
      do_rearm();
    end
    n_cmp++;
    if (ready_in_write != 0) begin n_bad++; $display("FAIL ready_in_write: got %0d cycles want 0", ready_in_write); end
  endtask

  task automatic test_reset_mid_data();
    load_good();
    tx = tx[0:4];
    send(0);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, im_we, start, done, error, im_addr, im_wdata} !== {1'b1, 4'b0, 8'h0, 32'h0}) begin
      n_bad++; $display("FAIL mid_reset: got rdy=%b we=%b dn=%b er=%b a=%h d=%h want rdy=1 rest 0",
                        byte_ready, im_we, done, error, im_addr, im_wdata);
    end
    @(negedge clk); rst = 1'b1;
    got_w.delete(); start_cnt = 0;
    load_good();
    send(1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got_w.size() != 2 || got_w[0] !== {8'h00, 32'h12345678} || got_w[1] !== {8'h01, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL after_reset_writes: got %0d writes want 2 correct words from addr 0", got_w.size());
    end
    n_cmp++;
    if ({done, start_cnt == 1} !== 2'b11) begin n_bad++; $display("FAIL after_reset_done: got done=%b starts=%0d want 1 1", done, start_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_too_large();
    test_zero_len_junk();
    test_back_to_back();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
